activation_scheduler: RTL and testbench
=======================================

ACTIVATION_SCHEDULER -- requirements
Module: activation_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sigtan activation unit (2..16).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for unit completion (>= 2).
REQ-003 Parameter IDW, default $clog2(NUM_REQ): requester-ID width.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rstn_i  input  1  reset, synchronous, active-low.
REQ-006 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-007 req_data_i  input  NUM_REQ*32  per-requester FP32 MAC result; slice i = bits [32i+31:32i].
REQ-008 req_func_i  input  NUM_REQ*2  per-requester function: 00 sigmoid, 01 tanh, 10/11 illegal.
REQ-009 req_ready_o  output  NUM_REQ  one-hot grant/accept strobe.
REQ-010 act_valid_o  output  1  start pulse to the activation unit valid_i.
REQ-011 act_data_o  output  32  operand to the activation unit mac_result.
REQ-012 act_sel_o  output  2  function to the activation unit select_sub.
REQ-013 act_done_i  input  1  activation unit done_o.
REQ-014 act_result_i  input  32  activation unit final_result_o.
REQ-015 rsp_valid_o  output  1  response valid.
REQ-016 rsp_ready_i  input  1  response consumer ready.
REQ-017 rsp_id_o  output  IDW  index of the requester owning the response.
REQ-018 rsp_data_o  output  32  FP32 activation result.
REQ-019 rsp_err_o  output  1  response carries an error (illegal func or timeout).
REQ-020 busy_o  output  1  high in every state other than IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with exactly one operation in flight at any time.
REQ-022 IDLE: if any req_valid_i bit is set, the block SHALL grant the first set bit searching round-robin from (last_grant+1) mod NUM_REQ, assert req_ready_o for that bit only in that cycle, capture its data, func and ID, and go to ISSUE.
REQ-023 req_ready_o SHALL be all-zero outside IDLE and in IDLE when there is no request; requesters hold req_valid_i and data until they are granted.
REQ-024 ISSUE, legal func: act_valid_o SHALL be 1 for exactly this one cycle, then the FSM goes to WAIT with the timeout counter cleared.
REQ-025 ISSUE, illegal func (10/11): no act_valid_o pulse; the FSM goes to RESP with rsp_err_o=1 and rsp_data_o=32'h0.
REQ-026 act_data_o and act_sel_o SHALL hold the captured values from ISSUE through the end of WAIT.
REQ-027 WAIT: the counter increments each cycle; on act_done_i=1 the block captures act_result_i, sets rsp_err_o=0 and goes to RESP.
REQ-028 WAIT: if the counter reaches TIMEOUT-1 with act_done_i=0, the FSM goes to RESP with rsp_err_o=1 and rsp_data_o=32'h7FC00000.
REQ-029 WAIT: if act_done_i=1 in the same cycle that the counter reaches TIMEOUT-1, done wins (no error).
REQ-030 act_done_i SHALL be ignored in IDLE, ISSUE and RESP.
REQ-031 RESP: rsp_valid_o=1 with rsp_id_o, rsp_data_o and rsp_err_o stable until rsp_ready_i=1; on that cycle the FSM goes to IDLE and last_grant takes the served ID.
REQ-032 Minimum latency: grant in cycle T, act_valid_o in T+1, and if done arrives in cycle D, rsp_valid_o from D+1; no new grant is made before the cycle after the response handshake.
REQ-033 The round-robin order SHALL guarantee that any continuously asserted request is served within NUM_REQ grants.

Reset
REQ-034 With rstn_i=0 at a rising edge, the block SHALL enter IDLE, set last_grant=NUM_REQ-1 (requester 0 has first priority), clear the counter, and drive every output to 0, including mid-operation.
REQ-035 A late act_done_i arriving after a reset SHALL be ignored.

Verification
REQ-036 Single sigmoid: req_valid_i=0001, data 32'h3F800000, func 00; act done after 5 cycles with 32'h3F3B26A6 -> act_valid_o pulses once, rsp_id_o=0, rsp_data_o=32'h3F3B26A6, rsp_err_o=0.
REQ-037 Fairness: req_valid_i=1111 held, rsp_ready_i=1, unit done 3 cycles after start -> grant order 0,1,2,3,0.
REQ-038 Illegal func 11 on requester 2 -> no act_valid_o, rsp_id_o=2, rsp_err_o=1, rsp_data_o=0.
REQ-039 Timeout: act_done_i held 0 -> RESP after exactly TIMEOUT cycles in WAIT with rsp_data_o=32'h7FC00000 and rsp_err_o=1; a late act_done_i is ignored.
REQ-040 Backpressure: rsp_ready_i=0 for 10 cycles -> rsp outputs stable, req_ready_o=0 throughout; done coincident with timeout -> no error.
REQ-041 Reset in WAIT -> next cycle busy_o=0 and all outputs 0; the next grant goes to requester 0.

Source files
------------

// File: rtl/activation_scheduler_if.sv
// Bundle of request, activation-unit and response signals around the activation scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface activation_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*32-1:0] req_data_i;
  logic [NUM_REQ*2-1:0]  req_func_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic                  act_valid_o;
  logic [31:0]           act_data_o;
  logic [1:0]            act_sel_o;
  logic                  act_done_i;
  logic [31:0]           act_result_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [31:0]           rsp_data_o;
  logic                  rsp_err_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_func_i, act_done_i, act_result_i, rsp_ready_i,
    output req_ready_o, act_valid_o, act_data_o, act_sel_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_func_i, act_done_i, act_result_i, rsp_ready_i,
    input  req_ready_o, act_valid_o, act_data_o, act_sel_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/activation_scheduler.sv
// Round-robin scheduler sharing one sigmoid/tanh activation unit among NUM_REQ requesters,
// one operation in flight, with illegal-function and completion-timeout error responses.
module activation_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  activation_scheduler_if.slave  bus
);

  localparam int          CW       = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN_VAL = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [31:0]        data_q, data_d;
  logic [1:0]         sel_q, sel_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               act_valid;
  logic               rsp_valid;

  // Search starts just after the last served requester, so a held request waits at most NUM_REQ grants.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && bus.req_valid_i[IDW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    sel_d        = sel_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    grant_oh     = '0;
    act_valid    = 1'b0;
    rsp_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          grant_oh[grant_idx] = 1'b1;
          id_d                = grant_idx;
          data_d              = bus.req_data_i[32*grant_idx +: 32];
          sel_d               = bus.req_func_i[2*grant_idx +: 2];
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (sel_q[1]) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          act_valid = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Completion is checked before the timeout so a coincident done is not an error.
        if (bus.act_done_i) begin
          rsp_data_d = bus.act_result_i;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d = QNAN_VAL;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready_i) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Grants are masked while reset is held so nothing looks accepted during reset.
  assign bus.req_ready_o = rstn_i ? grant_oh : '0;
  assign bus.act_valid_o = act_valid;
  assign bus.act_data_o  = (state_q == ISSUE || state_q == WAIT) ? data_q : '0;
  assign bus.act_sel_o   = (state_q == ISSUE || state_q == WAIT) ? sel_q : '0;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = rsp_valid ? id_q : '0;
  assign bus.rsp_data_o  = rsp_valid ? rsp_data_q : '0;
  assign bus.rsp_err_o   = rsp_valid ? rsp_err_q : 1'b0;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_activation_scheduler.sv
// Directed self-checking bench for activation_scheduler: single op, fairness, illegal func,
// timeout, backpressure with done at the timeout boundary, and reset mid-operation.
module tb_activation_scheduler;

  localparam int NR  = 4;
  localparam int TO  = 16;
  localparam int IDW = 2;

  logic clk;
  logic rstn;
  int   tests_run;
  int   tests_failed;
  int   pulses;
  int   wait_cycles;
  bit   stable;
  int   order [5] = '{0, 1, 2, 3, 0};

  activation_scheduler_if #(.NUM_REQ(NR), .IDW(IDW)) bus ();

  activation_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO), .IDW(IDW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [NR-1:0] valid, input logic [2*NR-1:0] func);
    bus.req_valid_i = valid;
    bus.req_func_i  = func;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn         = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.req_func_i   = '0;
    bus.act_done_i   = 1'b0;
    bus.act_result_i = '0;
    bus.rsp_ready_i  = 1'b0;
    repeat (2) tick();
    #1;
    check_output("reset_busy", 64'(bus.busy_o), 64'h0);
    check_output("reset_req_ready", 64'(bus.req_ready_o), 64'h0);
    check_output("reset_act_valid", 64'(bus.act_valid_o), 64'h0);
    check_output("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);

    // Single sigmoid on requester 0, done five cycles after the start pulse
    rstn = 1'b1;
    bus.req_data_i[31:0] = 32'h3F800000;
    apply_stimulus(4'b0001, 8'h00);
    #1;
    check_output("single_grant", 64'(bus.req_ready_o), 64'h1);
    tick();
    apply_stimulus(4'b0000, 8'h00);
    #1;
    check_output("single_act_valid", 64'(bus.act_valid_o), 64'h1);
    check_output("single_act_data", 64'(bus.act_data_o), 64'h3F800000);
    check_output("single_act_sel", 64'(bus.act_sel_o), 64'h0);
    check_output("single_busy", 64'(bus.busy_o), 64'h1);
    check_output("single_ready_issue", 64'(bus.req_ready_o), 64'h0);
    pulses = 1;
    repeat (4) begin
      tick();
      #1;
      pulses += int'(bus.act_valid_o);
    end
    tick();
    bus.act_done_i   = 1'b1;
    bus.act_result_i = 32'h3F3B26A6;
    #1;
    pulses += int'(bus.act_valid_o);
    tick();
    bus.act_done_i = 1'b0;
    #1;
    check_output("single_pulses", 64'(pulses), 64'd1);
    check_output("single_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    check_output("single_rsp_id", 64'(bus.rsp_id_o), 64'h0);
    check_output("single_rsp_data", 64'(bus.rsp_data_o), 64'h3F3B26A6);
    check_output("single_rsp_err", 64'(bus.rsp_err_o), 64'h0);
    bus.rsp_ready_i = 1'b1;
    tick();
    #1;
    check_output("single_idle_busy", 64'(bus.busy_o), 64'h0);

    // Fairness: all four hold requests, unit finishes three cycles after each start
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < NR; i++) bus.req_data_i[32*i +: 32] = 32'hA0000000 + i;
    apply_stimulus(4'b1111, 8'b01_00_01_00);
    bus.rsp_ready_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check_output($sformatf("fair_grant%0d", n), 64'(bus.req_ready_o), 64'(1 << order[n]));
      tick();
      #1;
      check_output($sformatf("fair_act_data%0d", n), 64'(bus.act_data_o), 64'(32'hA0000000 + order[n]));
      check_output($sformatf("fair_act_sel%0d", n), 64'(bus.act_sel_o), 64'(order[n] % 2));
      repeat (3) tick();
      bus.act_done_i   = 1'b1;
      bus.act_result_i = 32'h3F000000 + order[n];
      tick();
      bus.act_done_i = 1'b0;
      #1;
      check_output($sformatf("fair_rsp_id%0d", n), 64'(bus.rsp_id_o), 64'(order[n]));
      tick();
    end

    // Illegal function 11 on requester 2
    bus.rsp_ready_i = 1'b0;
    bus.req_data_i[95:64] = 32'hDEADBEEF;
    apply_stimulus(4'b0100, 8'b11_11_01_00);
    #1;
    check_output("illegal_grant", 64'(bus.req_ready_o), 64'h4);
    tick();
    apply_stimulus(4'b0000, 8'b00_00_01_00);
    #1;
    check_output("illegal_no_act", 64'(bus.act_valid_o), 64'h0);
    tick();
    #1;
    check_output("illegal_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    check_output("illegal_rsp_id", 64'(bus.rsp_id_o), 64'h2);
    check_output("illegal_rsp_err", 64'(bus.rsp_err_o), 64'h1);
    check_output("illegal_rsp_data", 64'(bus.rsp_data_o), 64'h0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;

    // Timeout on requester 1 (tanh), then a late done that must be ignored
    bus.req_data_i[63:32] = 32'hC0000000;
    apply_stimulus(4'b0010, 8'b00_00_01_00);
    #1;
    check_output("timeout_grant", 64'(bus.req_ready_o), 64'h2);
    tick();
    apply_stimulus(4'b0000, 8'b00_00_01_00);
    #1;
    check_output("timeout_act_valid", 64'(bus.act_valid_o), 64'h1);
    check_output("timeout_act_sel", 64'(bus.act_sel_o), 64'h1);
    wait_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      #1;
      if (bus.rsp_valid_o) break;
      wait_cycles++;
    end
    check_output("timeout_wait_cycles", 64'(wait_cycles), 64'(TO));
    check_output("timeout_rsp_valid", 64'(bus.rsp_valid_o), 64'h1);
    check_output("timeout_rsp_data", 64'(bus.rsp_data_o), 64'h7FC00000);
    check_output("timeout_rsp_err", 64'(bus.rsp_err_o), 64'h1);
    check_output("timeout_rsp_id", 64'(bus.rsp_id_o), 64'h1);
    bus.act_done_i   = 1'b1;
    bus.act_result_i = 32'h12345678;
    tick();
    #1;
    check_output("late_done_rsp_data", 64'(bus.rsp_data_o), 64'h7FC00000);
    bus.rsp_ready_i = 1'b1;
    tick();
    #1;
    check_output("late_done_idle", 64'(bus.busy_o), 64'h0);
    tick();
    #1;
    check_output("late_done_still_idle", 64'(bus.busy_o), 64'h0);
    bus.act_done_i  = 1'b0;
    bus.rsp_ready_i = 1'b0;

    // Done coincident with the last WAIT cycle, then ten cycles of response backpressure
    bus.req_data_i[31:0] = 32'h3E800000;
    apply_stimulus(4'b0001, 8'b00_00_01_00);
    #1;
    check_output("bp_grant", 64'(bus.req_ready_o), 64'h1);
    tick();
    apply_stimulus(4'b1110, 8'b00_00_01_00);
    #1;
    check_output("bp_act_valid", 64'(bus.act_valid_o), 64'h1);
    repeat (TO) tick();
    bus.act_done_i   = 1'b1;
    bus.act_result_i = 32'h3F000000;
    #1;
    check_output("bp_last_wait_no_rsp", 64'(bus.rsp_valid_o), 64'h0);
    tick();
    bus.act_done_i = 1'b0;
    #1;
    check_output("bp_rsp_err", 64'(bus.rsp_err_o), 64'h0);
    check_output("bp_rsp_data", 64'(bus.rsp_data_o), 64'h3F000000);
    check_output("bp_rsp_id", 64'(bus.rsp_id_o), 64'h0);
    stable = 1'b1;
    repeat (10) begin
      tick();
      #1;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h3F000000 ||
          bus.rsp_err_o !== 1'b0 || bus.rsp_id_o !== 2'd0 || bus.req_ready_o !== 4'b0000)
        stable = 1'b0;
    end
    check_output("bp_stable", 64'(stable), 64'h1);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    #1;
    check_output("bp_next_grant", 64'(bus.req_ready_o), 64'h2);

    // Reset while waiting on requester 1; afterwards requester 0 has priority again
    tick();
    apply_stimulus(4'b0000, 8'b00_00_01_00);
    repeat (2) tick();
    rstn = 1'b0;
    tick();
    #1;
    check_output("rst_wait_busy", 64'(bus.busy_o), 64'h0);
    check_output("rst_wait_req_ready", 64'(bus.req_ready_o), 64'h0);
    check_output("rst_wait_act_valid", 64'(bus.act_valid_o), 64'h0);
    check_output("rst_wait_act_data", 64'(bus.act_data_o), 64'h0);
    check_output("rst_wait_act_sel", 64'(bus.act_sel_o), 64'h0);
    check_output("rst_wait_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
    check_output("rst_wait_rsp_id", 64'(bus.rsp_id_o), 64'h0);
    check_output("rst_wait_rsp_data", 64'(bus.rsp_data_o), 64'h0);
    check_output("rst_wait_rsp_err", 64'(bus.rsp_err_o), 64'h0);
    rstn = 1'b1;
    bus.act_done_i   = 1'b1;
    bus.act_result_i = 32'hFFFFFFFF;
    tick();
    #1;
    check_output("rst_late_done_busy", 64'(bus.busy_o), 64'h0);
    check_output("rst_late_done_rsp", 64'(bus.rsp_valid_o), 64'h0);
    bus.act_done_i = 1'b0;
    apply_stimulus(4'b1111, 8'h00);
    #1;
    check_output("rst_first_grant", 64'(bus.req_ready_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
